// File: rtl/pri_arbiter_rr.sv
// Round-robin arbiter for up to NREQ requesters sharing one resource.
// A rotating pointer picks the first active request at or above it,
// wrapping from NREQ-1 to 0. The grant (one-hot plus binary ID) is
// registered and held until the owner strobes done, drops its request,
// or the hold counter reaches MAX_HOLD cycles. On release the next
// owner is picked in the same cycle, so a handover leaves no idle cycle.
// IDW must equal log2(NREQ); NREQ must be a power of two so that the
// pointer arithmetic wraps naturally modulo NREQ.
module pri_arbiter_rr #(
   parameter int NREQ     = 16,
   parameter int IDW      = 4,
   parameter int MAX_HOLD = 8
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            enable,
   input  logic [NREQ-1:0] req,
   input  logic            done,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  gnt_id,
   output logic            gnt_valid,
   output logic            timeout
);

   // Hold counter only needs to count up to MAX_HOLD-1.
   localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
   localparam bit TIMEOUT_EN = (MAX_HOLD > 0);
   localparam logic [HW-1:0]   HOLD_LAST = HW'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
   localparam logic [HW-1:0]   HOLD_ONE  = HW'(1);
   localparam logic [IDW-1:0]  ID_ONE    = IDW'(1);
   localparam logic [NREQ-1:0] ONE_HOT_LSB = NREQ'(1);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t          state_r, state_n;
   logic [IDW-1:0]  ptr_r, ptr_n;
   logic [HW-1:0]   hold_r, hold_n;
   logic [NREQ-1:0] gnt_r, gnt_n;
   logic [IDW-1:0]  gnt_id_r, gnt_id_n;
   logic            gnt_valid_r, gnt_valid_n;
   logic            timeout_r, timeout_n;

   logic [IDW-1:0]  arb_start_s;
   logic [IDW-1:0]  pick_s;
   logic            any_req_s;
   logic            owner_req_s;
   logic            hold_hit_s;
   logic            release_s;

   // First set bit of r searching upward from start, wrapping at NREQ-1.
   function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [IDW-1:0]  start);
      logic [IDW-1:0] idx;
      logic [IDW-1:0] pick;
      logic           found;
      pick  = '0;
      found = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         idx = start + IDW'(i);
         if (r[idx] && !found) begin
            pick  = idx;
            found = 1'b1;
         end else begin
            pick  = pick;
            found = found;
         end
      end
      return pick;
   endfunction

   // Release detection and the arbitration start point. On a release the
   // search begins just past the current owner, so the owner itself is
   // considered last.
   always_comb begin
      any_req_s   = |req;
      owner_req_s = req[gnt_id_r];
      hold_hit_s  = TIMEOUT_EN && (hold_r == HOLD_LAST);
      release_s   = done || !owner_req_s || hold_hit_s;
      if (state_r == GRANT) begin
         arb_start_s = gnt_id_r + ID_ONE;
      end else begin
         arb_start_s = ptr_r;
      end
      pick_s = rr_pick(req, arb_start_s);
   end

   // Next-state and next-output logic for the IDLE/GRANT machine.
   always_comb begin
      state_n     = state_r;
      ptr_n       = ptr_r;
      hold_n      = hold_r;
      gnt_n       = gnt_r;
      gnt_id_n    = gnt_id_r;
      gnt_valid_n = gnt_valid_r;
      timeout_n   = 1'b0;
      case (state_r)
         IDLE: begin
            hold_n = '0;
            if (enable && any_req_s) begin
               gnt_n       = ONE_HOT_LSB << pick_s;
               gnt_id_n    = pick_s;
               gnt_valid_n = 1'b1;
               state_n     = GRANT;
            end else begin
               gnt_n       = '0;
               gnt_id_n    = '0;
               gnt_valid_n = 1'b0;
               state_n     = IDLE;
            end
         end
         GRANT: begin
            if (release_s) begin
               ptr_n  = gnt_id_r + ID_ONE;
               hold_n = '0;
               // A forced release is flagged only when the owner neither
               // finished nor withdrew; done wins over the timeout.
               timeout_n = hold_hit_s && !done && owner_req_s;
               if (enable && any_req_s) begin
                  gnt_n       = ONE_HOT_LSB << pick_s;
                  gnt_id_n    = pick_s;
                  gnt_valid_n = 1'b1;
                  state_n     = GRANT;
               end else begin
                  gnt_n       = '0;
                  gnt_id_n    = '0;
                  gnt_valid_n = 1'b0;
                  state_n     = IDLE;
               end
            end else begin
               if (TIMEOUT_EN) begin
                  hold_n = hold_r + HOLD_ONE;
               end else begin
                  hold_n = hold_r;
               end
            end
         end
         default: begin
            state_n     = IDLE;
            ptr_n       = '0;
            hold_n      = '0;
            gnt_n       = '0;
            gnt_id_n    = '0;
            gnt_valid_n = 1'b0;
         end
      endcase
   end

   // State, pointer, counter and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= IDLE;
         ptr_r       <= '0;
         hold_r      <= '0;
         gnt_r       <= '0;
         gnt_id_r    <= '0;
         gnt_valid_r <= 1'b0;
         timeout_r   <= 1'b0;
      end else begin
         state_r     <= state_n;
         ptr_r       <= ptr_n;
         hold_r      <= hold_n;
         gnt_r       <= gnt_n;
         gnt_id_r    <= gnt_id_n;
         gnt_valid_r <= gnt_valid_n;
         timeout_r   <= timeout_n;
      end
   end

   assign gnt       = gnt_r;
   assign gnt_id    = gnt_id_r;
   assign gnt_valid = gnt_valid_r;
   assign timeout   = timeout_r;

endmodule

// File: tb/tb_pri_arbiter_rr.sv
// Directed bench for pri_arbiter_rr with NREQ=16, MAX_HOLD=8.
// Inputs change 1 time unit after a rising edge; outputs are checked
// at the same point, i.e. well away from the active edge.
module tb_pri_arbiter_rr;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        enable;
   logic [15:0] req;
   logic        done;
   logic [15:0] gnt;
   logic [3:0]  gnt_id;
   logic        gnt_valid;
   logic        timeout;

   int n_checks = 0;
   int n_fails  = 0;

   pri_arbiter_rr #(
      .NREQ     (16),
      .IDW      (4),
      .MAX_HOLD (8)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .enable    (enable),
      .req       (req),
      .done      (done),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   // Count one comparison and report it if it does not match.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Check the full grant output set.
   task automatic check_grant(input string tag, input logic [15:0] e_gnt,
                              input logic [3:0] e_id, input logic e_valid);
      check({tag, ".gnt"},       32'(gnt),       32'(e_gnt));
      check({tag, ".gnt_id"},    32'(gnt_id),    32'(e_id));
      check({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(e_valid));
   endtask

   initial begin
      reset_n = 1'b0;
      enable  = 1'b1;
      req     = 16'hFFFF;
      done    = 1'b0;

      // Reset holds everything at zero even with all requests active.
      step();
      step();
      check_grant("reset", 16'h0000, 4'd0, 1'b0);
      check("reset.timeout", 32'(timeout), 32'd0);

      // First grant one cycle after release of reset.
      reset_n = 1'b1;
      req     = 16'h0001;
      step();
      check_grant("first", 16'h0001, 4'd0, 1'b1);

      // Round-robin between 0 and 15 with done every cycle.
      req  = 16'h8001;
      done = 1'b1;
      step();
      check_grant("rr1", 16'h8000, 4'd15, 1'b1);
      step();
      check_grant("rr2", 16'h0001, 4'd0, 1'b1);
      step();
      check_grant("rr3", 16'h8000, 4'd15, 1'b1);

      // Owner drops request, nobody else asks: back to idle.
      done = 1'b0;
      req  = 16'h0000;
      step();
      check_grant("idle1", 16'h0000, 4'd0, 1'b0);

      // Wrap: grant 2, then release with req 0003 -> pointer 3 wraps to 0.
      req = 16'h0004;
      step();
      check_grant("wrap.a", 16'h0004, 4'd2, 1'b1);
      req  = 16'h0003;
      done = 1'b1;
      step();
      check_grant("wrap.b", 16'h0001, 4'd0, 1'b1);
      done = 1'b0;
      req  = 16'h0000;
      step();
      check_grant("idle2", 16'h0000, 4'd0, 1'b0);

      // Timeout: continuous owner 4 is forced off every 8 cycles and regranted.
      req = 16'h0010;
      step();
      check_grant("to.start", 16'h0010, 4'd4, 1'b1);
      check("to.start.timeout", 32'(timeout), 32'd0);
      for (int k = 1; k <= 16; k++) begin
         step();
         check("to.gnt_id", 32'(gnt_id), 32'd4);
         check("to.gnt_valid", 32'(gnt_valid), 32'd1);
         check($sformatf("to.timeout.%0d", k), 32'(timeout),
               (k == 8 || k == 16) ? 32'd1 : 32'd0);
      end

      // Enable drop does not abort the active grant.
      enable = 1'b0;
      req    = 16'h00F0;
      step();
      check_grant("en.hold1", 16'h0010, 4'd4, 1'b1);
      step();
      check_grant("en.hold2", 16'h0010, 4'd4, 1'b1);
      // done releases, no new grant while enable is low.
      done = 1'b1;
      step();
      check_grant("en.rel", 16'h0000, 4'd0, 1'b0);
      check("en.rel.timeout", 32'(timeout), 32'd0);
      step();
      check_grant("en.blocked", 16'h0000, 4'd0, 1'b0);
      done = 1'b0;

      // Grant id 9, then assert reset asynchronously mid-cycle.
      enable = 1'b1;
      req    = 16'h0200;
      step();
      check_grant("rst.pre", 16'h0200, 4'd9, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      check_grant("rst.async", 16'h0000, 4'd0, 1'b0);
      step();
      reset_n = 1'b1;
      req     = 16'h0600;
      step();
      check_grant("rst.ptr0", 16'h0200, 4'd9, 1'b1);

      // done coinciding with the hold limit: no timeout pulse.
      for (int k = 1; k <= 7; k++) begin
         step();
      end
      check_grant("co.pre", 16'h0200, 4'd9, 1'b1);
      done = 1'b1;
      step();
      check_grant("co.next", 16'h0400, 4'd10, 1'b1);
      check("co.timeout", 32'(timeout), 32'd0);
      done = 1'b0;
      step();
      check_grant("co.hold", 16'h0400, 4'd10, 1'b1);
      check("co.hold.timeout", 32'(timeout), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/pri_arbiter_rr.md
# pri_arbiter_rr

Round-robin arbiter that shares one resource (bus, encoder port or memory slot) among up to 16 requesters. Each cycle it priority-encodes the request vector starting from a rotating pointer and issues a registered one-hot grant with its binary ID. The grant is held until the owner releases it, its request drops, or a hold timeout forces a release. It sits between the requesting agents and the shared datapath, and drives the datapath's select/enable lines directly.

## Interface
Parameters:
- NREQ, 16, number of requesters; a power of two, 2..16
- IDW, 4, grant ID width; equals log2(NREQ)
- MAX_HOLD, 8, maximum consecutive grant cycles per owner; 0 disables the timeout

Ports:
- clk  input  1  rising-edge clock; the only clock
- reset_n  input  1  asynchronous, active-low reset
- enable  input  1  allows new grants when high
- req  input  NREQ  request vector; bit i high means requester i wants the resource
- done  input  1  owner release strobe; only meaningful while gnt_valid is high
- gnt  output  NREQ  one-hot grant, registered
- gnt_id  output  IDW  binary index of the granted requester, registered
- gnt_valid  output  1  a grant is active
- timeout  output  1  one-cycle pulse when a grant is forcibly released

## Operation
- Reset values: gnt=0, gnt_id=0, gnt_valid=0, timeout=0, pointer=0, hold counter=0, state IDLE.
- State machine has two states, IDLE and GRANT.
- **IDLE:** if enable=1 and req!=0, select the first set bit of req at or above the pointer, searching upward and wrapping from NREQ-1 to 0. Load gnt, gnt_id and gnt_valid=1, and go to GRANT. Otherwise stay in IDLE with outputs 0.
- **GRANT release condition:** any of the following:
  - done=1
  - req[gnt_id]=0
  - MAX_HOLD!=0 and the hold counter equals MAX_HOLD-1
- **GRANT with no release:** hold gnt and gnt_id, and increment the hold counter.
- **GRANT on release:**
  - Set pointer = (gnt_id+1) mod NREQ.
  - Clear the hold counter.
  - Arbitrate the same cycle using the new pointer start; req[gnt_id] is still eligible if it is set.
  - If enable=1 and any req bit is set, load the new grant with no gap and stay in GRANT.
  - Otherwise clear the outputs and go to IDLE.
- **Timeout:** timeout=1 for exactly the cycle after a release caused only by the counter, i.e. done=0 and req[gnt_id]=1. If done and the timeout coincide, done takes precedence and timeout stays 0.
- **enable=0:** never aborts an active grant; it only blocks new grants, including the back-to-back grant at release.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt==0 exactly when gnt_valid==0.
  - gnt_id==0 whenever gnt_valid==0.
- Hold counter width is max(1, clog2(MAX_HOLD)). It never wraps, because release occurs at MAX_HOLD-1.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Grant latency: req and enable sampled at edge N produce a grant visible after edge N. The earliest grant is one cycle after the request is raised.
- Release: done, or a dropped req, sampled at edge N removes or replaces the grant after edge N. The owner holds the resource for every cycle up to and including the one in which it drives done.
- Back-to-back handover has zero idle cycles.
- With MAX_HOLD=M, a continuous owner holds the grant for exactly M cycles.
- reset_n low clears all outputs immediately, without waiting for clk. Deassertion is synchronised by the integrator, and the first arbitration occurs at the first edge after deassertion.
- done while gnt_valid=0 is ignored. req changes on non-owner bits during GRANT have no effect until release.

## Test plan
- **Reset:** reset_n=0, req=16'hFFFF, enable=1 -> all outputs 0 and no grant. After release, req=16'h0001 -> gnt=16'h0001, gnt_id=0, gnt_valid=1 one cycle later.
- **Round-robin:** req=16'h8001 held, done pulsed in each grant cycle -> gnt_id sequence 0,15,0,15 with no idle cycles.
- **Wrap:** grant id 2, then done with req=16'h0003 -> pointer=3, search wraps, next gnt_id=0 (not 1).
- **Timeout:** MAX_HOLD=8, req=16'h0010 held, done never asserted -> gnt_id=4 for 8 cycles, timeout pulses once. Re-grant to id 4 follows immediately, and timeout repeats every 8 cycles.
- **Enable gating:** enable=0, req=16'h00F0 -> no grant. Grant id 4 active, then enable drops -> grant holds until done, then gnt_valid=0 while enable=0.
- **Reset mid-grant:** reset_n driven low asynchronously during gnt_id=9 -> outputs 0 before the next edge. After release, req=16'h0600 -> gnt_id=9 (pointer restarted at 0).
